// File: rtl/pd_loop_seq_pkg.sv
// Shared types for the PD loop sequencer: state codes, output vector, per-state output decode.
// Pure declarations; no logic, no latency, no flow control.
package pd_loop_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRECHG   = 3'd1,
    ST_PFD_ACQ  = 3'd2,
    ST_HANDOVER = 3'd3,
    ST_SSPD_TRK = 3'd4
  } pd_state_e;

  typedef struct packed {
    logic precharge;
    logic nrst_pfd;
    logic en_pfd;
    logic en_sspd;
    logic locked;
  } pd_out_t;

  // Indexed by state code; the illegal codes 5-7 decode to all-off.
  localparam pd_out_t PD_OUT_TBL [8] = '{
    5'b00000,  // IDLE
    5'b10000,  // PRECHG
    5'b01100,  // PFD_ACQ
    5'b01110,  // HANDOVER
    5'b01011,  // SSPD_TRK
    5'b00000,
    5'b00000,
    5'b00000
  };

endpackage

// File: rtl/pd_loop_runcnt.sv
// Saturating consecutive-run counter with clear/increment and a "reached N-1" flag.
// Count updates one cycle after clr/inc; hit is a combinational compare of the stored count.
module pd_loop_runcnt #(
  parameter int CNT_W = 8,
  parameter int N     = 32
) (
  input  logic clk_ref,
  input  logic nrst_dly,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_ref or negedge nrst_dly) begin
    if (!nrst_dly) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == LAST);

endmodule

// File: rtl/pd_loop_seq.sv
// PD loop mode sequencer: precharge -> PFD acquire -> handover -> SSPD track; outputs registered, 1 cycle after input sample.
// Optional SSPD_TRK loss-of-lock return to PFD_ACQ is built only when PD_LOOP_SEQ_AUTO_RELOCK_EN is defined.
module pd_loop_seq
  import pd_loop_seq_pkg::*;
#(
  parameter int PRECHG_CYC   = 64,
  parameter int LOCK_CNT     = 32,
  parameter int HANDOVER_CYC = 4,
  parameter int UNLOCK_CNT   = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk_ref,
  input  logic       nrst_dly,
  input  logic       start,
  input  logic       pfd_wide,
  output logic       precharge,
  output logic       nrst_pfd,
  output logic       en_pfd,
  output logic       en_sspd,
  output logic       locked,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] PRECHG_LAST   = CNT_W'(PRECHG_CYC - 1);
  localparam logic [CNT_W-1:0] HANDOVER_LAST = CNT_W'(HANDOVER_CYC - 1);

  pd_state_e        state_q, state_nxt;
  pd_out_t          out_q;
  logic [CNT_W-1:0] cyc_cnt;
  logic             state_chg;
  logic             lock_hit;
  logic             unlock_hit;

  assign state_chg = (state_nxt != state_q);

  pd_loop_runcnt #(.CNT_W(CNT_W), .N(LOCK_CNT)) u_lock_cnt (
    .clk_ref  (clk_ref),
    .nrst_dly (nrst_dly),
    .clr      (state_chg || (state_q != ST_PFD_ACQ) || pfd_wide),
    .inc      ((state_q == ST_PFD_ACQ) && !pfd_wide),
    .hit      (lock_hit)
  );

`ifdef PD_LOOP_SEQ_AUTO_RELOCK_EN
  pd_loop_runcnt #(.CNT_W(CNT_W), .N(UNLOCK_CNT)) u_unlock_cnt (
    .clk_ref  (clk_ref),
    .nrst_dly (nrst_dly),
    .clr      (state_chg || (state_q != ST_SSPD_TRK) || !pfd_wide),
    .inc      ((state_q == ST_SSPD_TRK) && pfd_wide),
    .hit      (unlock_hit)
  );
`else
  assign unlock_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    // Dropping start aborts from anywhere, ahead of every other transition.
    if ((state_q != ST_IDLE) && !start) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (start) state_nxt = ST_PRECHG;
        ST_PRECHG:   if (cyc_cnt == PRECHG_LAST) state_nxt = ST_PFD_ACQ;
        ST_PFD_ACQ:  if (lock_hit && !pfd_wide) state_nxt = ST_HANDOVER;
        ST_HANDOVER: if (cyc_cnt == HANDOVER_LAST) state_nxt = ST_SSPD_TRK;
        ST_SSPD_TRK: if (unlock_hit && pfd_wide) state_nxt = ST_PFD_ACQ;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ref or negedge nrst_dly) begin
    if (!nrst_dly) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cyc_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      // Decoding the next state keeps outputs aligned with the state register.
      out_q   <= PD_OUT_TBL[state_nxt];
      if (state_chg) begin
        cyc_cnt <= '0;
      end else if (cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
    end
  end

  assign precharge = out_q.precharge;
  assign nrst_pfd  = out_q.nrst_pfd;
  assign en_pfd    = out_q.en_pfd;
  assign en_sspd   = out_q.en_sspd;
  assign locked    = out_q.locked;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pd_loop_seq.sv
// Directed bench for pd_loop_seq with default parameters; unlock expectations follow PD_LOOP_SEQ_AUTO_RELOCK_EN.
// Outputs are sampled 1 ns after each rising clk_ref; inputs change right after sampling.
module tb_pd_loop_seq;

  logic       clk_ref;
  logic       nrst_dly;
  logic       start;
  logic       pfd_wide;
  logic       precharge, nrst_pfd, en_pfd, en_sspd, locked;
  logic [2:0] state_o;

  int n_assert = 0;
  int n_fail   = 0;

  pd_loop_seq dut (
    .clk_ref   (clk_ref),
    .nrst_dly  (nrst_dly),
    .start     (start),
    .pfd_wide  (pfd_wide),
    .precharge (precharge),
    .nrst_pfd  (nrst_pfd),
    .en_pfd    (en_pfd),
    .en_sspd   (en_sspd),
    .locked    (locked),
    .state_o   (state_o)
  );

  initial begin
    clk_ref = 1'b0;
    forever #5 clk_ref = ~clk_ref;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ref);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, precharge, nrst_pfd, en_pfd, en_sspd, locked};
  endfunction

  initial begin
    logic ok;
    nrst_dly = 1'b0;
    start    = 1'b0;
    pfd_wide = 1'b0;
    tick(3);
    chk("reset_state", state_o, 8'd0);
    chk("reset_outs", outs(), 8'h00);

    #3 nrst_dly = 1'b1;
    tick(1);
    chk("idle_no_start", state_o, 8'd0);

    // Bring-up: start is first sampled on edge 1.
    start = 1'b1;
    tick(1);
    chk("e1_prechg_state", state_o, 8'd1);
    chk("e1_prechg_outs", outs(), 8'b10000);
    ok = 1'b1;
    for (int i = 2; i <= 64; i++) begin
      tick(1);
      if (precharge !== 1'b1 || state_o !== 3'd1) ok = 1'b0;
    end
    chk("prechg_hold_64", ok, 1'b1);
    tick(1);
    chk("e65_acq_state", state_o, 8'd2);
    chk("e65_acq_outs", outs(), 8'b01100);
    tick(31);
    chk("e96_still_acq", state_o, 8'd2);
    tick(1);
    chk("e97_handover_state", state_o, 8'd3);
    chk("e97_handover_outs", outs(), 8'b01110);
    // pfd_wide is ignored during handover.
    pfd_wide = 1'b1;
    tick(3);
    chk("e100_handover_wide", state_o, 8'd3);
    pfd_wide = 1'b0;
    tick(1);
    chk("e101_track_state", state_o, 8'd4);
    chk("e101_track_outs", outs(), 8'b01011);

    // Seven wide cycles are short of the unlock threshold.
    pfd_wide = 1'b1;
    tick(7);
    pfd_wide = 1'b0;
    tick(1);
    chk("wide7_state", state_o, 8'd4);
    chk("wide7_locked", locked, 1'b1);

    pfd_wide = 1'b1;
    tick(7);
    chk("wide8_pre_locked", locked, 1'b1);
    tick(1);
    pfd_wide = 1'b0;
`ifdef PD_LOOP_SEQ_AUTO_RELOCK_EN
    chk("wide8_relock_state", state_o, 8'd2);
    chk("wide8_relock_outs", outs(), 8'b01100);
`else
    chk("wide8_hold_state", state_o, 8'd4);
    chk("wide8_hold_outs", outs(), 8'b01011);
`endif

    // Abort and restart, then exercise lock-run clearing.
    start = 1'b0;
    tick(1);
    chk("abort_state", state_o, 8'd0);
    chk("abort_outs", outs(), 8'h00);
    start = 1'b1;
    tick(1);
    chk("restart_prechg", state_o, 8'd1);
    tick(63);
    chk("restart_prechg_end", state_o, 8'd1);
    tick(1);
    chk("restart_acq", state_o, 8'd2);
    tick(20);
    pfd_wide = 1'b1;
    tick(1);
    pfd_wide = 1'b0;
    chk("pulse_clear_acq", state_o, 8'd2);
    tick(31);
    chk("clean31_acq", state_o, 8'd2);
    tick(1);
    chk("clean32_handover", state_o, 8'd3);
    chk("clean32_outs", outs(), 8'b01110);

    // start low during handover: one IDLE cycle, then a full-length precharge.
    start = 1'b0;
    tick(1);
    chk("ho_abort_state", state_o, 8'd0);
    chk("ho_abort_outs", outs(), 8'h00);
    start = 1'b1;
    tick(1);
    chk("ho_restart_outs", outs(), 8'b10000);
    tick(63);
    chk("ho_restart_prechg_end", precharge, 1'b1);
    tick(1);
    chk("ho_restart_acq", state_o, 8'd2);

    // Asynchronous reset in the middle of precharge.
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(10);
    chk("mid_prechg", precharge, 1'b1);
    #2 nrst_dly = 1'b0;
    #1;
    chk("async_rst_precharge", precharge, 1'b0);
    chk("async_rst_state", state_o, 8'd0);
    tick(2);
    #2 nrst_dly = 1'b1;
    #1;
    chk("rst_release_idle", state_o, 8'd0);
    tick(1);
    chk("rst_release_prechg", state_o, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_loop_seq.md
# pd_loop_seq

Reference-clock-domain sequencer that drives the mode controls of the phase-detector/charge-pump/loop-filter stage. It steps the loop through filter precharge, PFD frequency/phase acquisition, a PFD-to-SSPD handover, and SSPD tracking. Lock is qualified from a per-cycle PFD phase-error flag. It sits directly upstream of the PD stage and produces its PRECHARGE, NRST_PFD, EN_PFD and EN_SSPD inputs.

## Interface
Parameters:
- PRECHG_CYC, 64 — ref cycles PRECHARGE is held high.
- LOCK_CNT, 32 — consecutive in-window cycles required to declare lock.
- HANDOVER_CYC, 4 — ref cycles with PFD and SSPD both enabled.
- UNLOCK_CNT, 8 — consecutive out-of-window cycles that declare loss of lock.
- CNT_W, 8 — counter width; must satisfy 2^CNT_W > max(PRECHG_CYC, LOCK_CNT, HANDOVER_CYC, UNLOCK_CNT).

Ports:
- clk_ref  in  1  reference clock (DTC reference); all logic on rising edge.
- nrst_dly  in  1  reset nrst_dly, asynchronous, active-low.
- start  in  1  level; 1 = run the loop, 0 = abort to IDLE.
- pfd_wide  in  1  level, valid at rising clk_ref; 1 = last PFD pulse exceeded lock window.
- precharge  out  1  loop-filter precharge.
- nrst_pfd  out  1  PFD reset, active-low.
- en_pfd  out  1  PFD charge-pump enable.
- en_sspd  out  1  SSPD charge-pump enable.
- locked  out  1  loop locked (SSPD tracking).
- state_o  out  3  current state encoding (debug).

## Operation
- States: IDLE=0, PRECHG=1, PFD_ACQ=2, HANDOVER=3, SSPD_TRK=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- Output decode per state (precharge, nrst_pfd, en_pfd, en_sspd, locked):
  - IDLE: 0,0,0,0,0
  - PRECHG: 1,0,0,0,0
  - PFD_ACQ: 0,1,1,0,0
  - HANDOVER: 0,1,1,1,0
  - SSPD_TRK: 0,1,0,1,1
- IDLE -> PRECHG when start=1.
- PRECHG: cycle counter runs from 0; -> PFD_ACQ on the edge where the count equals PRECHG_CYC-1.
- PFD_ACQ:
  - Run counter increments each cycle with pfd_wide=0 and clears to 0 on pfd_wide=1.
  - -> HANDOVER on the edge where the counter equals LOCK_CNT-1 and pfd_wide=0.
- HANDOVER: cycle counter; -> SSPD_TRK after HANDOVER_CYC cycles. pfd_wide is ignored in this state.
- SSPD_TRK (auto-relock, see Configuration):
  - Run counter counts consecutive pfd_wide=1 cycles and clears on pfd_wide=0.
  - -> PFD_ACQ when the counter reaches UNLOCK_CNT-1 with pfd_wide=1.
- start=0 in any non-IDLE state -> IDLE on the next edge. This has priority over every other transition.
- Every state entry clears the shared counter to 0. Counters saturate at all-ones and never wrap.

## Timing
- Reset (nrst_dly=0, async): state=IDLE, all outputs 0, counters 0. Release is sampled on the next rising clk_ref.
- Outputs are registered and change on the same edge as the state register, one cycle after the qualifying input sample. There is no combinational input-to-output path.
- PRECHARGE high time is exactly PRECHG_CYC ref cycles.
- Minimum time from start to locked=1 is 1+PRECHG_CYC+LOCK_CNT+HANDOVER_CYC cycles.
- Reset asserted mid-operation: all outputs drop asynchronously. locked falls with no handover.
- start toggling 1->0->1 on consecutive edges: one IDLE cycle, then PRECHG restarts from count 0.

## Configuration
- PD_LOOP_SEQ_AUTO_RELOCK_EN defined: SSPD_TRK unlock detection is active as described above.
- Macro undefined:
  - The unlock counter and the SSPD_TRK->PFD_ACQ transition are not compiled in.
  - pfd_wide is ignored in SSPD_TRK.
  - locked stays 1 until start=0 or reset.

## Structure
- Package pd_loop_seq_pkg holds:
  - the state enum typedef (3-bit, explicit codes above);
  - a packed output-vector typedef;
  - the per-state output decode constant.
- Sub-module pd_loop_runcnt: a saturating consecutive-run counter with clear, increment and "reached N-1" compare. It is instantiated for lock qualification and, when the macro is defined, for unlock qualification.

## Test plan
- Reset then start=1 with defaults, pfd_wide=0 -> precharge high for exactly 64 cycles; en_pfd=1 at cycle 65; en_sspd=1 at cycle 97; locked=1 at cycle 101.
- PFD_ACQ with pfd_wide pulsed at in-window count 20 -> counter clears; HANDOVER entered only after 32 further clean cycles.
- SSPD_TRK with PD_LOOP_SEQ_AUTO_RELOCK_EN, pfd_wide=1 for 7 cycles then 0 -> stays locked. pfd_wide=1 for 8 cycles -> locked=0, en_sspd=0, en_pfd=1 in PFD_ACQ.
- The previous 8-cycle pfd_wide=1 stimulus without the macro -> locked stays 1.
- start=0 during HANDOVER -> next edge IDLE, all outputs 0. start=1 again -> PRECHG count restarts at 0.
- nrst_dly asserted mid-PRECHG (asynchronously, between clock edges) -> precharge falls with no clock edge; after release the state is IDLE.
